// File: rtl/instr_fetch_if.sv
// instr_fetch_if: bundles the instruction-memory read port, the redirect
// request and the fetch->decode valid/ready handshake.
//
//   im_addr      fetch -> IM      word-aligned byte address
//   im_instr     IM -> fetch      combinational read data for im_addr
//   redirect     later -> fetch   load redirect_pc and flush the queue
//   redirect_pc  later -> fetch   redirect target (bits [1:0] ignored)
//   id_valid     fetch -> decode  queue head holds an instruction
//   id_ready     decode -> fetch  decode accepts the head this cycle
//   id_instr     fetch -> decode  head instruction
//   id_pc        fetch -> decode  PC of the head instruction
//   id_pc_plus4  fetch -> decode  id_pc + 4
//   fetch_err    fetch -> env     sticky out-of-range flag
//
// master: the fetch stage.  slave: the surrounding memory/pipeline.
interface instr_fetch_if;
  logic [31:0] im_addr;
  logic [31:0] im_instr;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic        fetch_err;

  modport master (
    output im_addr,
    input  im_instr,
    input  redirect,
    input  redirect_pc,
    output id_valid,
    input  id_ready,
    output id_instr,
    output id_pc,
    output id_pc_plus4,
    output fetch_err
  );

  modport slave (
    input  im_addr,
    output im_instr,
    output redirect,
    output redirect_pc,
    input  id_valid,
    output id_ready,
    input  id_instr,
    input  id_pc,
    input  id_pc_plus4,
    input  fetch_err
  );
endinterface

// File: rtl/instr_fetch.sv
// instr_fetch: MIPS instruction fetch stage.
// Owns the PC, drives it as the IM address, captures returned words into a
// 2-entry queue and presents the head to decode with valid/ready.  A redirect
// flushes the queue and reloads the PC.  Fetching beyond the IM halts the
// stage and raises a sticky fetch_err until a redirect to a legal target.
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  instr_fetch_if.master (IM port, redirect, decode handshake, fetch_err)
module instr_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = 32
) (
  input  logic            clk,
  input  logic            rst,
  instr_fetch_if.master   bus
);

  // One bit wider than the PC so the bound itself cannot overflow.
  localparam logic [32:0] PC_LIMIT   = 33'(IMEM_WORDS) << 2;
  localparam logic [31:0] RESET_WORD = {RESET_PC[31:2], 2'b00};

  typedef enum logic {
    FETCH,
    HALT
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [1:0]  count_q, count_d;
  logic [31:0] q0_instr_q, q0_instr_d;
  logic [31:0] q0_pc_q, q0_pc_d;
  logic [31:0] q1_instr_q, q1_instr_d;
  logic [31:0] q1_pc_q, q1_pc_d;
  logic        err_q, err_d;

  logic        pop;
  logic        push;
  logic        pc_in_range;
  logic        target_in_range;
  logic [31:0] target_pc;
  logic [1:0]  occ_after_pop;
  logic [1:0]  redirect_pc_unused;

  assign redirect_pc_unused = bus.redirect_pc[1:0];

  assign target_pc       = {bus.redirect_pc[31:2], 2'b00};
  assign pc_in_range     = {1'b0, pc_q} < PC_LIMIT;
  assign target_in_range = {1'b0, target_pc} < PC_LIMIT;

  assign pop  = (count_q != 2'd0) && bus.id_ready;
  assign push = (state_q == FETCH) && !bus.redirect && pc_in_range &&
                ((count_q != 2'd2) || pop);

  // Occupancy once this cycle's pop has left; the push lands in that slot.
  assign occ_after_pop = count_q - {1'b0, pop};

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    if (bus.redirect) begin
      // An out-of-range target re-enters FETCH and halts again next cycle,
      // so the error is only cleared for a legal target.
      state_d = FETCH;
      if (target_in_range) begin
        err_d = 1'b0;
      end
    end else if ((state_q == FETCH) && !pc_in_range) begin
      state_d = HALT;
      err_d   = 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // PC and fetch queue
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_WORD;
      count_q    <= '0;
      q0_instr_q <= '0;
      q0_pc_q    <= '0;
      q1_instr_q <= '0;
      q1_pc_q    <= '0;
    end else begin
      pc_q       <= pc_d;
      count_q    <= count_d;
      q0_instr_q <= q0_instr_d;
      q0_pc_q    <= q0_pc_d;
      q1_instr_q <= q1_instr_d;
      q1_pc_q    <= q1_pc_d;
    end
  end

  always_comb begin
    pc_d       = pc_q;
    count_d    = count_q;
    q0_instr_d = q0_instr_q;
    q0_pc_d    = q0_pc_q;
    q1_instr_d = q1_instr_q;
    q1_pc_d    = q1_pc_q;

    if (bus.redirect) begin
      // Any same-cycle pop has already been taken by decode; the remaining
      // contents are simply abandoned by zeroing the count.
      count_d = '0;
      pc_d    = target_pc;
    end else begin
      if (pop) begin
        q0_instr_d = q1_instr_q;
        q0_pc_d    = q1_pc_q;
      end
      if (push) begin
        if (occ_after_pop == 2'd0) begin
          q0_instr_d = bus.im_instr;
          q0_pc_d    = pc_q;
        end else begin
          q1_instr_d = bus.im_instr;
          q1_pc_d    = pc_q;
        end
        pc_d = pc_q + 32'd4;
      end
      count_d = occ_after_pop + {1'b0, push};
    end
  end

  // ---------------------------------------------------------------------
  // Outputs: all from registers, none from im_instr.  The PC only moves on
  // a push or redirect, so im_addr is stable while the queue is stalled.
  // ---------------------------------------------------------------------
  assign bus.im_addr     = pc_q;
  assign bus.id_valid    = (count_q != 2'd0);
  assign bus.id_instr    = q0_instr_q;
  assign bus.id_pc       = q0_pc_q;
  assign bus.id_pc_plus4 = q0_pc_q + 32'd4;
  assign bus.fetch_err   = err_q;

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

  localparam int unsigned LIMIT_MAIN = 128;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] mem [0:31];

  instr_fetch_if b ();
  instr_fetch_if s ();

  assign b.im_instr = mem[b.im_addr[6:2]];
  assign s.im_instr = mem[s.im_addr[6:2]];

  instr_fetch #(.RESET_PC(32'h0000_0000), .IMEM_WORDS(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (b)
  );

  instr_fetch #(.RESET_PC(32'h0000_0000), .IMEM_WORDS(4)) dut_s (
    .clk (clk),
    .rst (rst),
    .bus (s)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic step(input bit rdy, input bit rd, input logic [31:0] rpc);
    b.id_ready    = rdy;
    b.redirect    = rd;
    b.redirect_pc = rpc;
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ------------------------------------------------------------------
  // Reference model: a queue of {instr, pc} plus pc / halted / err.
  // ------------------------------------------------------------------
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] mpc;
  bit          mhalt;
  bit          merr;

  task automatic model_reset();
    mq.delete();
    mpc   = 32'h0;
    mhalt = 1'b0;
    merr  = 1'b0;
  endtask

  task automatic model_edge(input bit rd, input logic [31:0] rpc, input bit rdy);
    bit          do_pop;
    bit          do_push;
    logic [31:0] tgt;
    ent_t        e;
    do_pop  = (mq.size() != 0) && rdy;
    do_push = !mhalt && !rd && (mpc < LIMIT_MAIN) && ((mq.size() < 2) || do_pop);
    if (do_pop) void'(mq.pop_front());
    if (rd) begin
      tgt = rpc & 32'hFFFF_FFFC;
      mq.delete();
      mhalt = 1'b0;
      if (tgt < LIMIT_MAIN) merr = 1'b0;
      mpc = tgt;
    end else begin
      if (!mhalt && (mpc >= LIMIT_MAIN)) begin
        mhalt = 1'b1;
        merr  = 1'b1;
      end
      if (do_push) begin
        e.instr = mem[mpc[6:2]];
        e.pc    = mpc;
        mq.push_back(e);
        mpc = mpc + 32'd4;
      end
    end
  endtask

  task automatic model_check();
    chk("rnd_valid", {31'b0, b.id_valid}, {31'b0, mq.size() != 0});
    chk("rnd_addr", b.im_addr, mpc);
    chk("rnd_err", {31'b0, b.fetch_err}, {31'b0, merr});
    if (mq.size() != 0) begin
      chk("rnd_pc", b.id_pc, mq[0].pc);
      chk("rnd_instr", b.id_instr, mq[0].instr);
      chk("rnd_plus4", b.id_pc_plus4, mq[0].pc + 32'd4);
    end
  endtask

  // ------------------------------------------------------------------
  // Directed vector table
  // ------------------------------------------------------------------
  typedef struct {
    bit          rdy;
    bit          rd;
    logic [31:0] rpc;
    bit          ev;
    logic [31:0] epc;
    logic [31:0] eaddr;
  } vec_t;

  vec_t tv [12];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    b.id_ready = 1'b0; b.redirect = 1'b0; b.redirect_pc = '0;
    s.id_ready = 1'b0; s.redirect = 1'b0; s.redirect_pc = '0;
    for (int unsigned k = 0; k < 32; k++) mem[k] = 32'hD92A4015 + k * 32'h801;

    // Reset values
    #2;
    chk("rst_addr", b.im_addr, 32'h0);
    chk("rst_valid", {31'b0, b.id_valid}, 32'h0);
    chk("rst_instr", b.id_instr, 32'h0);
    chk("rst_pc", b.id_pc, 32'h0);
    chk("rst_plus4", b.id_pc_plus4, 32'h4);
    chk("rst_err", {31'b0, b.fetch_err}, 32'h0);

    // Run, backpressure, redirect, redirect with simultaneous pop at count 2
    tv[0]  = '{rdy:1'b1, rd:1'b0, rpc:32'h0,  ev:1'b1, epc:32'h0,  eaddr:32'h4};
    tv[1]  = '{rdy:1'b1, rd:1'b0, rpc:32'h0,  ev:1'b1, epc:32'h4,  eaddr:32'h8};
    tv[2]  = '{rdy:1'b0, rd:1'b0, rpc:32'h0,  ev:1'b1, epc:32'h4,  eaddr:32'hC};
    tv[3]  = '{rdy:1'b0, rd:1'b0, rpc:32'h0,  ev:1'b1, epc:32'h4,  eaddr:32'hC};
    tv[4]  = '{rdy:1'b0, rd:1'b0, rpc:32'h0,  ev:1'b1, epc:32'h4,  eaddr:32'hC};
    tv[5]  = '{rdy:1'b1, rd:1'b0, rpc:32'h0,  ev:1'b1, epc:32'h8,  eaddr:32'h10};
    tv[6]  = '{rdy:1'b1, rd:1'b0, rpc:32'h0,  ev:1'b1, epc:32'hC,  eaddr:32'h14};
    tv[7]  = '{rdy:1'b1, rd:1'b1, rpc:32'h13, ev:1'b0, epc:32'h0,  eaddr:32'h10};
    tv[8]  = '{rdy:1'b1, rd:1'b0, rpc:32'h0,  ev:1'b1, epc:32'h10, eaddr:32'h14};
    tv[9]  = '{rdy:1'b0, rd:1'b0, rpc:32'h0,  ev:1'b1, epc:32'h10, eaddr:32'h18};
    tv[10] = '{rdy:1'b1, rd:1'b1, rpc:32'h40, ev:1'b0, epc:32'h0,  eaddr:32'h40};
    tv[11] = '{rdy:1'b1, rd:1'b0, rpc:32'h0,  ev:1'b1, epc:32'h40, eaddr:32'h44};

    @(negedge clk);
    rst = 1'b0;
    for (int unsigned i = 0; i < 12; i++) begin
      logic [31:0] ep;
      step(tv[i].rdy, tv[i].rd, tv[i].rpc);
      ep = tv[i].epc;
      chk($sformatf("tv%0d_valid", i), {31'b0, b.id_valid}, {31'b0, tv[i].ev});
      chk($sformatf("tv%0d_addr", i), b.im_addr, tv[i].eaddr);
      if (tv[i].ev) begin
        chk($sformatf("tv%0d_pc", i), b.id_pc, ep);
        chk($sformatf("tv%0d_instr", i), b.id_instr, mem[ep[6:2]]);
        chk($sformatf("tv%0d_plus4", i), b.id_pc_plus4, ep + 32'd4);
      end
      if (i == 0) chk("word0", b.id_instr, 32'hD92A4015);
      if (i == 1) chk("word1", b.id_instr, 32'hD92A4816);
    end

    // Backpressure from reset: 4 stalled cycles, then in-order delivery
    do_reset();
    for (int unsigned i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 32'h0);
      if (i > 0) chk("bp_addr_hold", b.im_addr, 32'h8);
    end
    for (int unsigned k = 0; k < 3; k++) begin
      chk("bp_order_pc", b.id_pc, 32'(k * 4));
      chk("bp_order_instr", b.id_instr, mem[k]);
      chk("bp_order_valid", {31'b0, b.id_valid}, 32'h1);
      step(1'b1, 1'b0, 32'h0);
    end

    // Halt at end of IM with a full queue, then asynchronous reset
    do_reset();
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h7B);
    chk("hr_redir_valid", {31'b0, b.id_valid}, 32'h0);
    chk("hr_redir_addr", b.im_addr, 32'h78);
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    chk("hr_pre_err", {31'b0, b.fetch_err}, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    chk("hr_err", {31'b0, b.fetch_err}, 32'h1);
    chk("hr_head", b.id_pc, 32'h78);
    chk("hr_addr", b.im_addr, 32'h80);
    @(posedge clk);
    #3;
    chk("ar_pre_valid", {31'b0, b.id_valid}, 32'h1);
    rst = 1'b1;
    #1;
    chk("ar_valid", {31'b0, b.id_valid}, 32'h0);
    chk("ar_addr", b.im_addr, 32'h0);
    chk("ar_err", {31'b0, b.fetch_err}, 32'h0);
    chk("ar_plus4", b.id_pc_plus4, 32'h4);
    @(negedge clk);
    rst = 1'b0;

    // Range halt on a 4-word IM, then recovery by redirect to 0
    do_reset();
    s.id_ready = 1'b1;
    s.redirect = 1'b0;
    for (int unsigned k = 0; k < 4; k++) begin
      tick();
      chk("sm_valid", {31'b0, s.id_valid}, 32'h1);
      chk("sm_pc", s.id_pc, 32'(k * 4));
      chk("sm_instr", s.id_instr, mem[k]);
      chk("sm_err0", {31'b0, s.fetch_err}, 32'h0);
    end
    for (int unsigned k = 0; k < 4; k++) begin
      tick();
      chk("sm_halt_err", {31'b0, s.fetch_err}, 32'h1);
      chk("sm_halt_valid", {31'b0, s.id_valid}, 32'h0);
      chk("sm_halt_addr", s.im_addr, 32'h10);
    end
    s.redirect = 1'b1;
    s.redirect_pc = 32'h0;
    tick();
    s.redirect = 1'b0;
    chk("sm_rec_err", {31'b0, s.fetch_err}, 32'h0);
    chk("sm_rec_addr", s.im_addr, 32'h0);
    chk("sm_rec_valid0", {31'b0, s.id_valid}, 32'h0);
    tick();
    chk("sm_rec_valid1", {31'b0, s.id_valid}, 32'h1);
    chk("sm_rec_pc", s.id_pc, 32'h0);

    // Randomized run against the reference model
    for (int unsigned k = 0; k < 32; k++) mem[k] = $urandom;
    do_reset();
    model_reset();
    for (int unsigned n = 0; n < 2000; n++) begin
      bit          rdy;
      bit          rd;
      logic [31:0] rpc;
      rdy = ($urandom_range(0, 3) != 0);
      rd  = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 3) == 0) rpc = $urandom_range(32'h80, 32'h200);
      else                           rpc = $urandom_range(0, 127);
      b.id_ready    = rdy;
      b.redirect    = rd;
      b.redirect_pc = rpc;
      @(posedge clk);
      model_edge(rd, rpc, rdy);
      @(negedge clk);
      model_check();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
